ascon_perm_engine: RTL
======================

# ascon_perm_engine

Parametrised Ascon-p permutation engine executing a run-time selectable number of rounds (p12/p8/p6 or any 1..12) with configurable round unrolling per clock. It replaces the fixed 12-round, one-round-per-cycle initialisation engine. It serves init, data-absorb and finalisation phases of the Ascon AEAD/hash datapath from a single instance. It uses a start/busy/done handshake, a synchronous abort, and an optional interrupt.

## Interface

- UNROLL, 1: rounds computed per clock. Legal values 1, 2, 3, 4.
- IRQ_EN, 1: 1 drives irq_o from done_o; 0 ties irq_o low.
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  launch request; sampled only in IDLE
- rounds_i  in  4  round count N, sampled with start_i
- abort_i  in  1  synchronous cancel of a running permutation
- state_i  in  5x64  input state x0..x4, sampled with start_i
- state_o  out  5x64  permutation result, registered
- busy_o  out  1  permutation in progress
- done_o  out  1  one-cycle completion pulse
- irq_o  out  1  interrupt, equal to done_o when IRQ_EN=1

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE with start_i=1:
  - Latch state_i into the internal state register.
  - Round index r is set to 12 - N.
  - Go to BUSY.
- IDLE with start_i=1 and N=0:
  - Latch state_i and go directly to DONE.
  - The state is passed through unchanged.
- N > 12 is clamped to 12.
- BUSY, each cycle:
  - Apply k = min(UNROLL, 12 - r) consecutive rounds, starting at round index r.
  - Set r <= r + k.
  - When r + k == 12, go to DONE.
  - Unused unrolled stages in the final cycle are bypassed.
- Round i: constant addition, then S-box layer, then linear layer.
  - Constant c_i = ((15-i)<<4) | i, XORed into the low byte of x2.
  - p12 constants therefore run 0xf0 .. 0x4b; p6 starts at 0x96.
- DONE: done_o=1 for exactly one cycle, then return to IDLE.
  - A start_i in the DONE cycle is ignored.
- state_o reflects the internal state register.
  - It holds the final result from DONE until the next accepted start.
  - Intermediate values are visible while busy_o=1; consumers must qualify with done_o.
- start_i while BUSY or DONE is ignored; no queuing.
- abort_i in BUSY or DONE:
  - Return to IDLE next cycle.
  - Zero the state register; no done_o pulse.
  - abort_i wins over completion in the same cycle.
- abort_i in IDLE has no effect.
- abort_i and start_i together in IDLE: start is accepted.
- Round counter is 4 bits and never exceeds 12; no wrap-around.

## Timing

- Reset values: busy_o=0, done_o=0, irq_o=0, state_o=0. FSM=IDLE, r=0.
- Reset is asynchronous and takes effect mid-permutation. No done_o is generated for the interrupted run.
- Let L = ceil(N/UNROLL) for N ≥ 1.
- Cycle 0: start_i sampled high in IDLE.
- Cycles 1..L: busy_o=1.
- Cycle L+1: done_o=1, busy_o=0, state_o equals the final result.
- Earliest next start is accepted in cycle L+2.
- N=0: done_o in cycle 1, state_o equals state_i from cycle 0.
- Throughput: one permutation per L+2 cycles.
- The critical path grows linearly with UNROLL; there are no multicycle paths.

## Test plan

- UNROLL=1, N=12, state_i = Ascon-128 IV/key/nonce init vector:
  - busy_o high cycles 1..12, done_o in cycle 13.
  - state_o matches the golden C model p12 output bit-exact.
- UNROLL=4, N=6 and N=8, random states:
  - Latencies 2 and 2 cycles (done_o in cycle 3).
  - Results equal the UNROLL=1 run and the golden p6/p8 model.
- UNROLL=3, N=8: cycles apply 3, 3 and 2 rounds; done_o in cycle 4; result matches golden p8.
- N=0: done_o in cycle 1, state_o == state_i. N=15: behaves identically to N=12.
- abort_i asserted in cycle 5 of a UNROLL=1, N=12 run:
  - IDLE in cycle 6, state_o=0, no done_o.
  - A new start in cycle 6 completes normally.
- start_i held high continuously:
  - Back-to-back runs are accepted exactly every L+2 cycles.
  - start_i during BUSY/DONE is ignored.
  - rst_n_i pulse mid-run zeroes all outputs immediately.

Source files
------------

// File: rtl/ascon_perm_if.sv
// Handshake bundle for the Ascon-p permutation engine.
// Ports: start_i/rounds_i/state_i launch a run, abort_i cancels it;
//        state_o/busy_o/done_o/irq_o report progress and the result.
interface ascon_perm_if;
  logic              start_i;
  logic [3:0]        rounds_i;
  logic              abort_i;
  logic [4:0][63:0]  state_i;
  logic [4:0][63:0]  state_o;
  logic              busy_o;
  logic              done_o;
  logic              irq_o;

  modport master (
    output start_i, rounds_i, abort_i, state_i,
    input  state_o, busy_o, done_o, irq_o
  );

  modport slave (
    input  start_i, rounds_i, abort_i, state_i,
    output state_o, busy_o, done_o, irq_o
  );
endinterface

// File: rtl/ascon_perm_engine.sv
// Ascon-p permutation engine: N rounds (1..12, 0 = pass-through), UNROLL rounds per clock.
// Latency: ceil(N/UNROLL) busy cycles after the start cycle, then a one-cycle done_o pulse.
// Backpressure: none; start_i is only accepted in IDLE, abort_i cancels a run and zeroes the state.
// Ports: clk_i, rst_n_i (async, active-low), bus (slave side of ascon_perm_if):
//   start_i/rounds_i/state_i sampled in IDLE, abort_i, state_o (register), busy_o, done_o, irq_o.
module ascon_perm_engine #(
  parameter int UNROLL = 1,
  parameter bit IRQ_EN = 1'b1
) (
  input logic         clk_i,
  input logic         rst_n_i,
  ascon_perm_if.slave bus
);
  typedef logic [4:0][63:0] state_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'd12;
  localparam logic [3:0] UNROLL_W   = 4'(UNROLL);

  if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1..4");
  end

  fsm_t       fsm_q, fsm_d;
  state_t     st_q, st_d, st_rnd;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] rnd_left, rnd_step, rnd_clamp;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round with index i: constant add, bitsliced S-box, linear layer.
  function automatic state_t ascon_round(input state_t s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    state_t      r;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    // (15-i) in 4 bits is simply ~i.
    x2 = x2 ^ {56'd0, ~i, i};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    r[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    r[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    r[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    r[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    r[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return r;
  endfunction

  // Unrolled round chain; stages whose index reaches 12 pass the state through.
  // rnd_q <= 11 while busy, so rnd_q + 3 cannot overflow 4 bits.
  always_comb begin
    st_rnd = st_q;
    for (int u = 0; u < UNROLL; u++) begin
      if ((rnd_q + 4'(u)) < LAST_ROUND) begin
        st_rnd = ascon_round(st_rnd, rnd_q + 4'(u));
      end
    end
  end

  assign rnd_left  = LAST_ROUND - rnd_q;
  assign rnd_step  = (rnd_left < UNROLL_W) ? rnd_left : UNROLL_W;
  assign rnd_clamp = (bus.rounds_i > LAST_ROUND) ? LAST_ROUND : bus.rounds_i;

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    rnd_d = rnd_q;
    unique case (fsm_q)
      IDLE: begin
        // abort_i is ignored here, so start wins when both are high.
        if (bus.start_i) begin
          st_d  = bus.state_i;
          rnd_d = LAST_ROUND - rnd_clamp;
          fsm_d = (rnd_clamp == 4'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus.abort_i) begin
          fsm_d = IDLE;
          st_d  = '0;
          rnd_d = '0;
        end else begin
          st_d  = st_rnd;
          rnd_d = rnd_q + rnd_step;
          if ((rnd_q + rnd_step) == LAST_ROUND) begin
            fsm_d = DONE;
          end
        end
      end
      DONE: begin
        fsm_d = IDLE;
        if (bus.abort_i) begin
          st_d  = '0;
          rnd_d = '0;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q <= IDLE;
      st_q  <= '0;
      rnd_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      rnd_q <= rnd_d;
    end
  end

  assign bus.state_o = st_q;
  assign bus.busy_o  = (fsm_q == BUSY);
  assign bus.done_o  = (fsm_q == DONE);
  assign bus.irq_o   = IRQ_EN & (fsm_q == DONE);
endmodule
